// File: rtl/q_update_engine.sv
// Tabular Q-learning update engine: 16-state x 4-action table of unsigned 16-bit Q values,
// one Bellman update per request through a fixed five-state pipeline.
module q_update_engine #(
  parameter int unsigned ALPHA_SHIFT = 2,
  parameter int unsigned GAMMA_SHIFT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  state,
  input  logic [3:0]  action,
  input  logic [15:0] reward,
  input  logic [3:0]  next_state,
  input  logic        terminal,
  input  logic [3:0]  rd_state,
  output logic [63:0] rd_q_values,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, FETCH, MAXQ, CALC, WRITE} fsm_t;

  fsm_t        fsm_q, fsm_d;
  logic [63:0] table_q [16];
  logic [63:0] table_d [16];
  logic [3:0]  s_q, s_d, ns_q, ns_d, a_q, a_d;
  logic [15:0] r_q, r_d;
  logic        term_q, term_d;
  logic [15:0] q_old_q, q_old_d;
  logic [63:0] row_next_q, row_next_d;
  logic [15:0] max_q, max_d;
  logic [15:0] q_new_q, q_new_d;
  logic        done_q, done_d, err_q, err_d;

  logic signed [17:0] r_ext, m_ext, m_shift, target, q_old_ext, delta, delta_sh, q_sum;
  logic [15:0] max01, max23;

  // Action 0 lives in the top 16 bits of a row, action 3 in the bottom.
  function automatic logic [15:0] entry_of(input logic [63:0] row, input logic [1:0] a);
    logic [15:0] e;
    case (a)
      2'd0:    e = row[63:48];
      2'd1:    e = row[47:32];
      2'd2:    e = row[31:16];
      default: e = row[15:0];
    endcase
    return e;
  endfunction

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (start) fsm_d = FETCH;
      FETCH:   fsm_d = MAXQ;
      MAXQ:    fsm_d = CALC;
      CALC:    fsm_d = WRITE;
      WRITE:   fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_comb begin
    s_d        = s_q;
    a_d        = a_q;
    r_d        = r_q;
    ns_d       = ns_q;
    term_d     = term_q;
    q_old_d    = q_old_q;
    row_next_d = row_next_q;
    if (fsm_q == IDLE && start) begin
      s_d    = state;
      a_d    = action;
      r_d    = reward;
      ns_d   = next_state;
      term_d = terminal;
    end
    if (fsm_q == FETCH) begin
      q_old_d    = entry_of(table_q[s_q], a_q[1:0]);
      row_next_d = table_q[ns_q];
    end
  end

  always_comb begin
    max01 = (row_next_q[63:48] > row_next_q[47:32]) ? row_next_q[63:48] : row_next_q[47:32];
    max23 = (row_next_q[31:16] > row_next_q[15:0])  ? row_next_q[31:16] : row_next_q[15:0];
    max_d = max_q;
    if (fsm_q == MAXQ) max_d = term_q ? 16'd0 : ((max01 > max23) ? max01 : max23);
  end

  // 18 bits hold every intermediate: target spans about -32768..98302, delta about -98303..98302.
  always_comb begin
    r_ext     = {{2{r_q[15]}}, r_q};
    m_ext     = {2'b00, max_q};
    m_shift   = m_ext >>> GAMMA_SHIFT;
    target    = r_ext + m_ext - m_shift;
    q_old_ext = {2'b00, q_old_q};
    delta     = target - q_old_ext;
    delta_sh  = delta >>> ALPHA_SHIFT;
    q_sum     = q_old_ext + delta_sh;
    q_new_d   = q_new_q;
    if (fsm_q == CALC) begin
      if (q_sum[17])      q_new_d = 16'd0;
      else if (q_sum[16]) q_new_d = 16'hFFFF;
      else                q_new_d = q_sum[15:0];
    end
  end

  always_comb begin
    for (int i = 0; i < 16; i++) table_d[i] = table_q[i];
    if (fsm_q == WRITE && a_q <= 4'd3) begin
      case (a_q[1:0])
        2'd0:    table_d[s_q][63:48] = q_new_q;
        2'd1:    table_d[s_q][47:32] = q_new_q;
        2'd2:    table_d[s_q][31:16] = q_new_q;
        default: table_d[s_q][15:0]  = q_new_q;
      endcase
    end
    done_d = (fsm_q == WRITE);
    err_d  = (fsm_q == WRITE) && (a_q > 4'd3);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q      <= IDLE;
      for (int i = 0; i < 16; i++) table_q[i] <= '0;
      s_q        <= '0;
      a_q        <= '0;
      r_q        <= '0;
      ns_q       <= '0;
      term_q     <= 1'b0;
      q_old_q    <= '0;
      row_next_q <= '0;
      max_q      <= '0;
      q_new_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      for (int i = 0; i < 16; i++) table_q[i] <= table_d[i];
      s_q        <= s_d;
      a_q        <= a_d;
      r_q        <= r_d;
      ns_q       <= ns_d;
      term_q     <= term_d;
      q_old_q    <= q_old_d;
      row_next_q <= row_next_d;
      max_q      <= max_d;
      q_new_q    <= q_new_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign rd_q_values = table_q[rd_state];
  assign busy        = (fsm_q != IDLE);
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_q_update_engine.sv
// Self-checking bench for q_update_engine: fixed vectors, hand-written corner sequences
// and randomized updates compared against an integer model of the Q table.
module tb_q_update_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  state, action, next_state, rd_state;
  logic [15:0] reward;
  logic        terminal;
  logic [63:0] rd_q_values;
  logic        busy, done, err;

  int n_total = 0;
  int n_pass  = 0;
  int model [16][4];

  q_update_engine #(.ALPHA_SHIFT(2), .GAMMA_SHIFT(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .state(state), .action(action),
    .reward(reward), .next_state(next_state), .terminal(terminal), .rd_state(rd_state),
    .rd_q_values(rd_q_values), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  s;
    logic [3:0]  a;
    logic [15:0] r;
    logic [3:0]  ns;
    logic        t;
    logic [63:0] exp_row;
    logic        exp_err;
  } vec_t;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_total++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", name, actual, expected);
  endtask

  function automatic logic [63:0] model_row(input int s);
    logic [63:0] row;
    for (int a = 0; a < 4; a++) row[16*(3-a) +: 16] = 16'(model[s][a]);
    return row;
  endfunction

  function automatic int floor_div(input int x, input int d);
    return (x >= 0) ? x / d : -((-x + d - 1) / d);
  endfunction

  // Bellman update with alpha = 1/4, gamma = 7/8, worked out in plain integers.
  task automatic model_apply(input int s, input int a, input int r, input int ns, input bit t);
    int m, target, q_old, q_new;
    if (a > 3) return;
    m = 0;
    if (!t) for (int i = 0; i < 4; i++) if (model[ns][i] > m) m = model[ns][i];
    target = r + m - floor_div(m, 8);
    q_old  = model[s][a];
    q_new  = q_old + floor_div(target - q_old, 4);
    if (q_new < 0) q_new = 0;
    if (q_new > 65535) q_new = 65535;
    model[s][a] = q_new;
  endtask

  task automatic model_clear();
    for (int s = 0; s < 16; s++) for (int a = 0; a < 4; a++) model[s][a] = 0;
  endtask

  task automatic read_row(input int s, output logic [63:0] row);
    rd_state = 4'(s);
    #1;
    row = rd_q_values;
  endtask

  // Issues one update, scrambles the inputs right after acceptance, and checks
  // completion timing, err and the resulting row of s.
  task automatic apply_stimulus(input logic [3:0] s, input logic [3:0] a, input logic [15:0] r,
                                input logic [3:0] ns, input logic t, output logic [63:0] row);
    int lat;
    logic err_seen;
    @(negedge clk);
    state = s; action = a; reward = r; next_state = ns; terminal = t; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    state = 4'($urandom); action = 4'($urandom); reward = 16'($urandom);
    next_state = 4'($urandom); terminal = 1'($urandom);
    model_apply(s, a, $signed(r), ns, t);
    lat = -1;
    err_seen = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (i > 1) begin
        @(posedge clk);
        #1;
      end
      if (done) begin
        lat = i - 1;
        err_seen = err;
        break;
      end
    end
    check_output("done_latency", 64'(lat), 64'd4);
    check_output("err", {63'd0, err_seen}, {63'd0, a > 4'd3});
    @(posedge clk);
    #1;
    check_output("done_one_cycle", {63'd0, done}, 64'd0);
    read_row(s, row);
    check_output("row_s", row, model_row(s));
  endtask

  initial begin
    vec_t vecs [6];
    logic [63:0] row;
    int dones;

    rst_n = 1'b0; start = 1'b0; state = '0; action = '0; reward = '0;
    next_state = '0; terminal = 1'b0; rd_state = '0;
    model_clear();
    #12;
    for (int s = 0; s < 16; s++) begin
      read_row(s, row);
      check_output("reset_row", row, 64'd0);
    end
    check_output("reset_busy", {63'd0, busy}, 64'd0);
    check_output("reset_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    vecs[0] = '{4'd0, 4'd3, 16'd256,    4'd9, 1'b1, 64'h0000_0000_0000_0040, 1'b0};
    vecs[1] = '{4'd1, 4'd0, 16'd256,    4'd0, 1'b0, 64'h004E_0000_0000_0000, 1'b0};
    vecs[2] = '{4'd2, 4'd1, 16'hFC00,   4'd5, 1'b1, 64'h0000_0000_0000_0000, 1'b0};
    vecs[3] = '{4'd3, 4'd5, 16'd1000,   4'd0, 1'b0, 64'h0000_0000_0000_0000, 1'b1};
    vecs[4] = '{4'd0, 4'd2, 16'hFFFC,   4'd1, 1'b0, 64'h0000_0000_0010_0040, 1'b0};
    vecs[5] = '{4'd0, 4'd3, 16'd0,      4'd0, 1'b0, 64'h0000_0000_0010_003E, 1'b0};
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(vecs[i].s, vecs[i].a, vecs[i].r, vecs[i].ns, vecs[i].t, row);
      check_output("vector_row", row, vecs[i].exp_row);
    end
    for (int s = 0; s < 16; s++) begin
      read_row(s, row);
      check_output("table_sweep", row, model_row(s));
    end

    // Start held high through the whole busy window must yield exactly one update.
    @(negedge clk);
    state = 4'd7; action = 4'd1; reward = 16'd400; next_state = 4'd3; terminal = 1'b1; start = 1'b1;
    @(posedge clk);
    model_apply(7, 1, 400, 3, 1'b1);
    dones = 0;
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk);
      #1;
      if (i == 4) start = 1'b0;
      if (done) dones++;
    end
    check_output("single_done", 64'(dones), 64'd1);
    read_row(7, row);
    check_output("busy_start_row", row, 64'h0000_0064_0000_0000);

    // Reset during CALC abandons the update and clears everything.
    @(negedge clk);
    state = 4'd6; action = 4'd2; reward = 16'd1000; next_state = 4'd1; terminal = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    check_output("mid_reset_busy", {63'd0, busy}, 64'd0);
    check_output("mid_reset_done", {63'd0, done}, 64'd0);
    read_row(6, row);
    check_output("mid_reset_row", row, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check_output("no_done_after_reset", 64'(dones), 64'd0);
    read_row(6, row);
    check_output("row_after_reset", row, 64'd0);
    apply_stimulus(4'd6, 4'd2, 16'd1000, 4'd1, 1'b1, row);
    check_output("post_reset_update", row, 64'h0000_0000_00FA_0000);

    // Randomized updates, biased toward a few states and large rewards to reach saturation.
    for (int i = 0; i < 60; i++) begin
      logic [15:0] r;
      r = ($urandom_range(0, 3) == 0) ? 16'h7FFF : 16'($urandom);
      apply_stimulus(4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)), r,
                     4'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), row);
    end
    for (int s = 0; s < 16; s++) begin
      read_row(s, row);
      check_output("final_sweep", row, model_row(s));
    end

    $display("[TB] %0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
